// File: rtl/bsg_link_downstream_mc.sv
// Multi-channel link receiver: reassembles io flits into core words, buffers them
// per channel in a small FIFO and returns a credit token toggle per batch of pops.
module bsg_link_downstream_mc #(
    parameter int IO_W        = 8,
    parameter int RATIO       = 4,
    parameter int CHANNELS    = 2,
    parameter int DEPTH       = 8,
    parameter int TOKEN_BATCH = 2,
    localparam int CORE_W     = IO_W * RATIO,
    localparam int OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          io_valid_i,
    input  logic [CHANNELS*IO_W-1:0]     io_data_i,
    output logic [CHANNELS-1:0]          core_valid_o,
    output logic [CHANNELS*CORE_W-1:0]   core_data_o,
    input  logic [CHANNELS-1:0]          core_yumi_i,
    output logic [CHANNELS-1:0]          token_o,
    output logic [CHANNELS-1:0]          overflow_o,
    output logic [CHANNELS*OCC_W-1:0]    occupancy_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int POP_W = (TOKEN_BATCH > 1) ? $clog2(TOKEN_BATCH) : 1;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [CNT_W-1:0]  cnt_reg;
            logic [CORE_W-1:0] asm_reg;
            logic [CORE_W-1:0] word_next;
            logic [PTR_W-1:0]  wptr_reg;
            logic [PTR_W-1:0]  rptr_reg;
            logic [POP_W-1:0]  pop_cnt_reg;
            logic              token_reg;
            logic              overflow_reg;
            logic [CORE_W-1:0] mem [DEPTH];
            logic              last_flit;
            logic              full;
            logic              empty;
            logic              push;
            logic              pop;

            assign last_flit = io_valid_i[gi] && (cnt_reg == CNT_W'(RATIO - 1));
            assign empty     = (wptr_reg == rptr_reg);
            assign full      = (wptr_reg[AW] != rptr_reg[AW]) &&
                               (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
            assign pop       = core_yumi_i[gi] && !empty;
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            assign push      = last_flit && (!full || pop);

            always_comb begin
                word_next = asm_reg;
                word_next[cnt_reg*IO_W +: IO_W] = io_data_i[gi*IO_W +: IO_W];
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg      <= '0;
                    asm_reg      <= '0;
                    wptr_reg     <= '0;
                    rptr_reg     <= '0;
                    pop_cnt_reg  <= '0;
                    token_reg    <= 1'b0;
                    overflow_reg <= 1'b0;
                end else begin
                    if (io_valid_i[gi]) begin
                        asm_reg <= word_next;
                        cnt_reg <= last_flit ? '0 : cnt_reg + CNT_W'(1);
                    end
                    if (push) begin
                        wptr_reg <= wptr_reg + PTR_W'(1);
                    end
                    if (last_flit && full && !pop) begin
                        overflow_reg <= 1'b1;
                    end
                    if (pop) begin
                        rptr_reg <= rptr_reg + PTR_W'(1);
                        if (pop_cnt_reg == POP_W'(TOKEN_BATCH - 1)) begin
                            pop_cnt_reg <= '0;
                            token_reg   <= ~token_reg;
                        end else begin
                            pop_cnt_reg <= pop_cnt_reg + POP_W'(1);
                        end
                    end
                end
            end

            // Storage is deliberately left out of reset.
            always_ff @(posedge clk) begin
                if (rst && push) begin
                    mem[wptr_reg[AW-1:0]] <= word_next;
                end
            end

            assign core_valid_o[gi]                  = !empty;
            assign core_data_o[gi*CORE_W +: CORE_W]  = mem[rptr_reg[AW-1:0]];
            assign token_o[gi]                       = token_reg;
            assign overflow_o[gi]                    = overflow_reg;
            assign occupancy_o[gi*OCC_W +: OCC_W]    = OCC_W'(wptr_reg - rptr_reg);
        end
    endgenerate

endmodule

// File: tb/tb_bsg_link_downstream_mc.sv
// Directed testbench for bsg_link_downstream_mc with default parameters.
module tb_bsg_link_downstream_mc;

    logic        clk;
    logic        rst;
    logic [1:0]  io_valid;
    logic [15:0] io_data;
    logic [1:0]  core_valid;
    logic [63:0] core_data;
    logic [1:0]  core_yumi;
    logic [1:0]  token;
    logic [1:0]  overflow;
    logic [7:0]  occupancy;

    int errors = 0;
    int checks = 0;

    bsg_link_downstream_mc dut (
        .clk          (clk),
        .rst          (rst),
        .io_valid_i   (io_valid),
        .io_data_i    (io_data),
        .core_valid_o (core_valid),
        .core_data_o  (core_data),
        .core_yumi_i  (core_yumi),
        .token_o      (token),
        .overflow_o   (overflow),
        .occupancy_o  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // One clock of stimulus; outputs are stable 1 time unit after the edge.
    task automatic step(input logic [1:0] v, input logic [15:0] d, input logic [1:0] y);
        io_valid  = v;
        io_data   = d;
        core_yumi = y;
        @(posedge clk);
        #1;
        io_valid  = '0;
        core_yumi = '0;
    endtask

    task automatic push_word(input int ch, input logic [31:0] w);
        logic [1:0] m;
        m = 2'b01 << ch;
        for (int k = 0; k < 4; k++) begin
            step(m, {w[k*8 +: 8], w[k*8 +: 8]}, 2'b00);
        end
    endtask

    task automatic pop(input int ch);
        logic [1:0] m;
        m = 2'b01 << ch;
        step(2'b00, 16'h0, m);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2'b00, 16'h0, 2'b00);
        step(2'b00, 16'h0, 2'b00);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (core_valid !== 2'b00) begin
            errors++; $display("FAIL reset_valid: got %b want 00", core_valid);
        end
        checks++;
        if (token !== 2'b00) begin
            errors++; $display("FAIL reset_token: got %b want 00", token);
        end
        checks++;
        if (overflow !== 2'b00) begin
            errors++; $display("FAIL reset_overflow: got %b want 00", overflow);
        end
        checks++;
        if (occupancy !== 8'h00) begin
            errors++; $display("FAIL reset_occupancy: got %h want 00", occupancy);
        end
        $display("test_reset done");
    endtask

    task automatic test_assemble();
        step(2'b01, 16'h0011, 2'b00);
        step(2'b01, 16'h0022, 2'b00);
        step(2'b01, 16'h0033, 2'b00);
        checks++;
        if (core_valid[0] !== 1'b0) begin
            errors++; $display("FAIL asm_early_valid: got %b want 0", core_valid[0]);
        end
        step(2'b01, 16'h0044, 2'b00);
        checks++;
        if (core_valid !== 2'b01) begin
            errors++; $display("FAIL asm_valid: got %b want 01", core_valid);
        end
        checks++;
        if (core_data[31:0] !== 32'h44332211) begin
            errors++; $display("FAIL asm_data: got %h want 44332211", core_data[31:0]);
        end
        checks++;
        if (occupancy !== 8'h01) begin
            errors++; $display("FAIL asm_occupancy: got %h want 01", occupancy);
        end
        pop(0);
        checks++;
        if (occupancy !== 8'h00 || core_valid !== 2'b00) begin
            errors++; $display("FAIL asm_drain: got occ=%h valid=%b want occ=00 valid=00", occupancy, core_valid);
        end
        $display("test_assemble done");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push_word(0, 32'hA000_0000 + 32'(i));
            if (i == 7) begin
                checks++;
                if (occupancy[3:0] !== 4'd8 || overflow[0] !== 1'b0) begin
                    errors++; $display("FAIL ovf_fill: got occ=%0d ovf=%b want occ=8 ovf=0", occupancy[3:0], overflow[0]);
                end
            end
        end
        checks++;
        if (occupancy[3:0] !== 4'd8 || overflow !== 2'b01) begin
            errors++; $display("FAIL ovf_flag: got occ=%0d ovf=%b want occ=8 ovf=01", occupancy[3:0], overflow);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (core_valid[0] !== 1'b1 || core_data[31:0] !== 32'hA000_0000 + 32'(i)) begin
                errors++; $display("FAIL ovf_drain%0d: got v=%b d=%h want v=1 d=%h", i, core_valid[0], core_data[31:0], 32'hA000_0000 + 32'(i));
            end
            pop(0);
        end
        checks++;
        if (occupancy[3:0] !== 4'd0 || overflow[0] !== 1'b1 || token[0] !== 1'b0) begin
            errors++; $display("FAIL ovf_end: got occ=%0d ovf=%b tok=%b want occ=0 ovf=1 tok=0", occupancy[3:0], overflow[0], token[0]);
        end
        $display("test_overflow done");
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int i = 0; i < 8; i++) push_word(0, 32'hB000_0000 + 32'(i));
        step(2'b01, 16'h00C1, 2'b00);
        step(2'b01, 16'h00C2, 2'b00);
        step(2'b01, 16'h00C3, 2'b00);
        step(2'b01, 16'h00C4, 2'b01);
        checks++;
        if (occupancy[3:0] !== 4'd8 || overflow[0] !== 1'b0) begin
            errors++; $display("FAIL full_pp: got occ=%0d ovf=%b want occ=8 ovf=0", occupancy[3:0], overflow[0]);
        end
        for (int i = 1; i < 9; i++) begin
            logic [31:0] exp;
            exp = (i == 8) ? 32'hC4C3C2C1 : 32'hB000_0000 + 32'(i);
            checks++;
            if (core_data[31:0] !== exp) begin
                errors++; $display("FAIL full_drain%0d: got %h want %h", i, core_data[31:0], exp);
            end
            pop(0);
        end
        $display("test_push_pop_full done");
    endtask

    task automatic test_token();
        logic [4:0] exp_tok;
        exp_tok = 5'b00110;  // token after pop 1..5, bit index = pop-1
        do_reset();
        for (int i = 0; i < 5; i++) push_word(1, 32'hD000_0000 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (core_data[63:32] !== 32'hD000_0000 + 32'(i)) begin
                errors++; $display("FAIL tok_data%0d: got %h want %h", i, core_data[63:32], 32'hD000_0000 + 32'(i));
            end
            pop(1);
            checks++;
            if (token[1] !== exp_tok[i]) begin
                errors++; $display("FAIL tok_pop%0d: got %b want %b", i + 1, token[1], exp_tok[i]);
            end
        end
        // Pop counter sits at 1, so the next single pop must toggle.
        push_word(1, 32'hD000_0005);
        pop(1);
        checks++;
        if (token !== 2'b10) begin
            errors++; $display("FAIL tok_counter: got %b want 10", token);
        end
        $display("test_token done");
    endtask

    task automatic test_reset_midword();
        do_reset();
        for (int i = 0; i < 3; i++) push_word(0, 32'hE000_0000 + 32'(i));
        step(2'b01, 16'h00AA, 2'b00);
        step(2'b01, 16'h00BB, 2'b00);
        rst = 1'b0;
        step(2'b11, 16'hCCCC, 2'b11);
        rst = 1'b1;
        checks++;
        if (core_valid !== 2'b00 || occupancy !== 8'h00 || token !== 2'b00 || overflow !== 2'b00) begin
            errors++; $display("FAIL rstmid_outputs: got v=%b occ=%h tok=%b ovf=%b want all zero", core_valid, occupancy, token, overflow);
        end
        push_word(0, 32'h04030201);
        checks++;
        if (core_data[31:0] !== 32'h04030201 || occupancy !== 8'h01) begin
            errors++; $display("FAIL rstmid_word: got d=%h occ=%h want d=04030201 occ=01", core_data[31:0], occupancy);
        end
        $display("test_reset_midword done");
    endtask

    task automatic test_empty_yumi();
        do_reset();
        for (int i = 0; i < 3; i++) pop(1);
        checks++;
        if (occupancy !== 8'h00 || token !== 2'b00 || core_valid !== 2'b00) begin
            errors++; $display("FAIL empty_yumi: got occ=%h tok=%b v=%b want 00/00/00", occupancy, token, core_valid);
        end
        push_word(1, 32'h12345678);
        push_word(1, 32'h9ABCDEF0);
        pop(1);
        checks++;
        if (token[1] !== 1'b0 || occupancy[7:4] !== 4'd1) begin
            errors++; $display("FAIL empty_first_pop: got tok=%b occ=%0d want tok=0 occ=1", token[1], occupancy[7:4]);
        end
        pop(1);
        checks++;
        if (token[1] !== 1'b1 || occupancy[7:4] !== 4'd0) begin
            errors++; $display("FAIL empty_second_pop: got tok=%b occ=%0d want tok=1 occ=0", token[1], occupancy[7:4]);
        end
        $display("test_empty_yumi done");
    endtask

    initial begin
        rst       = 1'b0;
        io_valid  = '0;
        io_data   = '0;
        core_yumi = '0;
        test_reset();
        test_assemble();
        test_overflow();
        test_push_pop_full();
        test_token();
        test_reset_midword();
        test_empty_yumi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_link_downstream_mc.md
BSG_LINK_DOWNSTREAM_MC -- requirements
Module: bsg_link_downstream_mc

Interface
REQ-001 Parameter IO_W, default 8: width of one io flit per channel.
REQ-002 Parameter RATIO, default 4, legal values >=1: flits per core word; CORE_W = IO_W*RATIO.
REQ-003 Parameter CHANNELS, default 2, legal values >=1: number of independent lanes.
REQ-004 Parameter DEPTH, default 8, power of 2, >=2: core words buffered per channel; OCC_W = $clog2(DEPTH+1).
REQ-005 Parameter TOKEN_BATCH, default 2, legal values >=1: dequeued words per returned token toggle.
REQ-006 clk  in  1  single clock; all state updates on posedge.
REQ-007 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-008 io_valid_i  in  CHANNELS  flit valid per channel.
REQ-009 io_data_i  in  CHANNELS*IO_W  flit data; channel c occupies bits [c*IO_W +: IO_W].
REQ-010 core_valid_o  out  CHANNELS  head word present per channel.
REQ-011 core_data_o  out  CHANNELS*CORE_W  head word; channel c occupies bits [c*CORE_W +: CORE_W].
REQ-012 core_yumi_i  in  CHANNELS  consumer takes the head word this cycle.
REQ-013 token_o  out  CHANNELS  credit-return toggle per channel.
REQ-014 overflow_o  out  CHANNELS  sticky overflow error flag.
REQ-015 occupancy_o  out  CHANNELS*OCC_W  words buffered per channel.

Function
REQ-016 Channels are fully independent and share only clk and rst.
REQ-017 Assembler: a per-channel flit counter runs 0..RATIO-1 and advances only on io_valid_i[c]; the flit taken at count k fills word slice [k*IO_W +: IO_W], so flit 0 lands in the LSBs.
REQ-018 On a valid flit with count == RATIO-1, the completed word, including that flit, is pushed the same edge and the counter wraps to 0; with RATIO=1 every valid flit is a word.
REQ-019 FIFO: circular buffer of DEPTH entries with pointers of $clog2(DEPTH)+1 bits; full and empty are decided by the wrap bit; pointers wrap modulo 2*DEPTH.
REQ-020 core_valid_o[c] = (occupancy != 0) and core_data_o shows the head entry; no bypass, so a word pushed at edge N is visible after edge N, and an empty FIFO gives 1 cycle latency.
REQ-021 Pop happens when core_yumi_i[c] && core_valid_o[c]; yumi while not valid is ignored with no state change.
REQ-022 Push and pop in the same cycle: both occur and occupancy is unchanged, including when full; no overflow is flagged.
REQ-023 Push while full with no pop: the word is dropped, overflow_o[c] is set and held until reset, the assembler still wraps, and FIFO contents are unchanged.
REQ-024 occupancy_o[c] = pushes minus pops, range 0..DEPTH, registered.
REQ-025 Token: a per-channel pop counter runs 0..TOKEN_BATCH-1; a pop at count TOKEN_BATCH-1 toggles token_o[c] on that edge and wraps the counter; at most one toggle per cycle.
REQ-026 No combinational path from any input to any output; all outputs derive from registers.

Reset
REQ-027 While rst==0 at a posedge, for every channel: flit counter, pointers, pop counter = 0; core_valid_o = 0; token_o = 0; overflow_o = 0; occupancy_o = 0.
REQ-028 Reset dominates: io_valid_i and core_yumi_i in a reset cycle are ignored, and a partially assembled word is discarded.
REQ-029 FIFO storage is not reset; core_data_o is don't-care while core_valid_o = 0.

Verification
REQ-030 Defaults; ch0 flits 0x11,0x22,0x33,0x44 on consecutive cycles -> the cycle after the 4th flit core_valid_o[0]=1, core_data_o[31:0]=0x44332211, occupancy 1; ch1 stays idle.
REQ-031 Push 9 words into ch0 with no yumi -> occupancy 8 after word 8; word 9 dropped; overflow_o[0]=1; draining 8 yumis returns words 1..8 in order.
REQ-032 ch0 full (8); last flit and yumi in the same cycle -> occupancy stays 8, overflow_o[0] stays 0, new word at tail.
REQ-033 Pop 5 words from ch1 -> token_o[1] toggles after pops 2 and 4 (0->1->0); after pop 5 the pop counter = 1 and token_o[1]=0.
REQ-034 Assert rst=0 after 2 of 4 flits with 3 words queued -> all outputs reset; next 4 flits form a fresh word in LSB order.
REQ-035 Yumi asserted on an empty channel -> no occupancy underflow and no token toggle.
